// File: rtl/rmst_trans_arbiter.sv
// rmst_trans_arbiter
//   Shares one external-memory read channel between three tile load
//   controllers (0 = input fmap, 1 = weights, 2 = output fmap). Each
//   requester can have one pending transaction. Pending requests are granted
//   round-robin, one at a time. The granted address and length go to the
//   memory read master, and its completion pulse is routed back to the owner.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_trans_start[2:0]     per-requester one-cycle start pulse
//   req_raddr{0,1,2}         byte address, sampled with start
//   req_iolen{0,1,2}         burst length in words, sampled with start
//   req_trans_done[2:0]      one-cycle completion pulse to the owner
//   mem_trans_start          one-cycle start pulse to the memory read master
//   mem_raddr, mem_iolen     granted transaction; held until done
//   mem_trans_done           completion pulse from the memory read master
//   grant_id                 current / last granted requester
//   busy                     arbiter is not idle
//   req_overflow[2:0]        sticky: start seen while already pending
module rmst_trans_arbiter #(
  parameter int AW = 12,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    req_trans_start,
  input  logic [DW-1:0] req_raddr0,
  input  logic [DW-1:0] req_raddr1,
  input  logic [DW-1:0] req_raddr2,
  input  logic [AW-1:0] req_iolen0,
  input  logic [AW-1:0] req_iolen1,
  input  logic [AW-1:0] req_iolen2,
  output logic [2:0]    req_trans_done,
  output logic          mem_trans_start,
  output logic [DW-1:0] mem_raddr,
  output logic [AW-1:0] mem_iolen,
  input  logic          mem_trans_done,
  output logic [1:0]    grant_id,
  output logic          busy,
  output logic [2:0]    req_overflow
);

  localparam int NREQ = 3;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT,
    ARB_DONE
  } arb_state_e;

  arb_state_e state_q;

  logic [NREQ-1:0]          pend_q, pend_d;
  logic [NREQ-1:0]          ovf_q, ovf_d;
  logic [NREQ-1:0]          cap, clr;
  logic [NREQ-1:0][DW-1:0]  req_addr, hold_addr_q;
  logic [NREQ-1:0][AW-1:0]  req_len, hold_len_q;
  logic [1:0]               last_q, grant_q, pick_idx;
  logic                     pick_vld, fin;
  logic                     start_q;
  logic [NREQ-1:0]          done_q;
  logic [DW-1:0]            raddr_q;
  logic [AW-1:0]            iolen_q;

  assign req_addr = {req_raddr2, req_raddr1, req_raddr0};
  assign req_len  = {req_iolen2, req_iolen1, req_iolen0};

  // Round-robin pick: scan last+3, last+2, last+1 so the closest pending
  // index after the last grant is the one left in pick_idx.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = 2'd0;
    for (int k = NREQ; k >= 1; k--) begin
      if (pend_q[(int'(last_q) + k) % NREQ]) begin
        pick_vld = 1'b1;
        pick_idx = 2'((int'(last_q) + k) % NREQ);
      end
    end
  end

  // A done accepted in WAIT frees the owner's slot. A start from that owner
  // in the same cycle is captured (set wins) and is not treated as overflow.
  assign fin = (state_q == ARB_WAIT) && mem_trans_done;

  always_comb begin
    clr = '0;
    cap = '0;
    for (int i = 0; i < NREQ; i++) begin
      clr[i] = fin && (grant_q == 2'(i));
      cap[i] = req_trans_start[i] && (!pend_q[i] || clr[i]);
    end
    pend_d = (pend_q & ~clr) | cap;
    ovf_d  = ovf_q | (req_trans_start & pend_q & ~clr);
  end

  // Pending flags, overflow flags and per-requester holding registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q      <= '0;
      ovf_q       <= '0;
      hold_addr_q <= '0;
      hold_len_q  <= '0;
    end else begin
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
      for (int i = 0; i < NREQ; i++) begin
        if (cap[i]) begin
          hold_addr_q[i] <= req_addr[i];
          hold_len_q[i]  <= req_len[i];
        end
      end
    end
  end

  // Grant FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      start_q <= 1'b0;
      done_q  <= '0;
      grant_q <= 2'd0;
      last_q  <= 2'd2;
      raddr_q <= '0;
      iolen_q <= '0;
    end else begin
      start_q <= 1'b0;
      done_q  <= '0;
      case (state_q)
        ARB_IDLE: begin
          if (pick_vld) begin
            grant_q <= pick_idx;
            raddr_q <= hold_addr_q[pick_idx];
            iolen_q <= hold_len_q[pick_idx];
            start_q <= 1'b1;
            state_q <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: state_q <= ARB_WAIT;
        ARB_WAIT: begin
          if (mem_trans_done) begin
            last_q          <= grant_q;
            done_q[grant_q] <= 1'b1;
            state_q         <= ARB_DONE;
          end
        end
        ARB_DONE: state_q <= ARB_IDLE;
        default:  state_q <= ARB_IDLE;
      endcase
    end
  end

  assign mem_trans_start = start_q;
  assign mem_raddr       = raddr_q;
  assign mem_iolen       = iolen_q;
  assign req_trans_done  = done_q;
  assign grant_id        = grant_q;
  assign busy            = (state_q != ARB_IDLE);
  assign req_overflow    = ovf_q;

endmodule

// File: tb/tb_rmst_trans_arbiter.sv
// Bench for rmst_trans_arbiter: a per-cycle table for the single-request
// case, short directed sequences for the multi-cycle corners, and random
// traffic checked every cycle against a timed transaction-level model.
module tb_rmst_trans_arbiter;
  localparam int AW = 12;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [2:0]    st = '0;
  logic [DW-1:0] a0 = '0, a1 = '0, a2 = '0;
  logic [AW-1:0] l0 = '0, l1 = '0, l2 = '0;
  logic          dn = 1'b0;
  logic [2:0]    req_trans_done;
  logic          mem_trans_start;
  logic [DW-1:0] mem_raddr;
  logic [AW-1:0] mem_iolen;
  logic [1:0]    grant_id;
  logic          busy;
  logic [2:0]    req_overflow;

  always #5 clk = ~clk;

  rmst_trans_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .req_trans_start(st),
    .req_raddr0(a0), .req_raddr1(a1), .req_raddr2(a2),
    .req_iolen0(l0), .req_iolen1(l1), .req_iolen2(l2),
    .req_trans_done(req_trans_done), .mem_trans_start(mem_trans_start),
    .mem_raddr(mem_raddr), .mem_iolen(mem_iolen), .mem_trans_done(dn),
    .grant_id(grant_id), .busy(busy), .req_overflow(req_overflow)
  );

  int n_cmp = 0, n_bad = 0, cyc = 0;
  bit chk_en = 0;

  // Reference model: pending set, holding values, who owns the channel,
  // when it was issued and the first cycle the channel can issue again.
  bit            m_pend[3];
  logic [DW-1:0] m_ha[3];
  logic [AW-1:0] m_hl[3];
  int            m_last, m_cur, m_issue, m_idle_from;
  logic          e_start, e_busy;
  logic [DW-1:0] e_raddr;
  logic [AW-1:0] e_len;
  logic [1:0]    e_gid;
  logic [2:0]    e_rdone, e_ovf;

  logic [DW-1:0] iss_q[$];
  logic [1:0]    gnt_q[$];
  logic [2:0]    done_q[$];
  bit auto_resp = 0;
  int resp_dly = 2, resp_cnt = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_pend[i] = 0; m_ha[i] = '0; m_hl[i] = '0;
    end
    m_last = 2; m_cur = -1; m_issue = 0; m_idle_from = 0;
    e_start = 0; e_busy = 0; e_raddr = '0; e_len = '0; e_gid = '0;
    e_rdone = '0; e_ovf = '0;
  endtask

  // Advance the model across the edge that ends the current cycle.
  task automatic model_step();
    logic [DW-1:0] ai[3];
    logic [AW-1:0] li[3];
    int g;
    ai[0] = a0; ai[1] = a1; ai[2] = a2;
    li[0] = l0; li[1] = l1; li[2] = l2;
    e_start = 0;
    e_rdone = '0;
    if (rst) begin
      model_reset();
      return;
    end
    if (m_cur < 0 && cyc >= m_idle_from && (m_pend[0] || m_pend[1] || m_pend[2])) begin
      g = -1;
      for (int k = 1; k <= 3; k++)
        if (g < 0 && m_pend[(m_last + k) % 3]) g = (m_last + k) % 3;
      m_cur = g; m_issue = cyc + 1;
      e_start = 1; e_raddr = m_ha[g]; e_len = m_hl[g]; e_gid = 2'(g);
    end else if (m_cur >= 0 && dn && cyc >= m_issue + 1) begin
      e_rdone[m_cur] = 1'b1;
      m_pend[m_cur] = 0;
      m_last = m_cur; m_cur = -1; m_idle_from = cyc + 2;
    end
    for (int i = 0; i < 3; i++) begin
      if (st[i]) begin
        if (!m_pend[i]) begin
          m_pend[i] = 1; m_ha[i] = ai[i]; m_hl[i] = li[i];
        end else e_ovf[i] = 1'b1;
      end
    end
    e_busy = (m_cur >= 0) || (cyc + 1 < m_idle_from);
  endtask

  // One clock cycle: compare, monitor, respond, update model, advance.
  task automatic tick();
    if (chk_en)
      chk($sformatf("cycle{start,raddr,len,gid,busy,done,ovf}"),
          {mem_trans_start, mem_raddr, mem_iolen, grant_id, busy, req_trans_done, req_overflow},
          {e_start, e_raddr, e_len, e_gid, e_busy, e_rdone, e_ovf});
    if (mem_trans_start === 1'b1) begin
      iss_q.push_back(mem_raddr);
      gnt_q.push_back(grant_id);
    end
    if (req_trans_done !== 3'b000) done_q.push_back(req_trans_done);
    if (auto_resp) begin
      if (resp_cnt == 1) begin dn = 1'b1; resp_cnt = 0; end
      else if (resp_cnt > 1) resp_cnt--;
      if (mem_trans_start === 1'b1) resp_cnt = resp_dly;
    end
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    st = '0; dn = 1'b0; rst = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    chk_en = 1;
    iss_q.delete(); gnt_q.delete(); done_q.delete();
    resp_cnt = 0;
  endtask

  typedef struct {
    logic [2:0] st;
    logic       dn;
    logic       xs;
    logic [1:0] xg;
    logic [2:0] xd;
    logic       xb;
  } vec_t;
  vec_t tbl[13];

  initial begin
    // Single request from requester 1: issue in cycle 2, done driven in
    // cycle 10, owner pulse in cycle 11, idle again in cycle 12.
    for (int r = 0; r < 13; r++) begin
      tbl[r].st = 3'b000;
      tbl[r].dn = (r == 10);
      tbl[r].xs = (r == 2);
      tbl[r].xg = (r >= 2) ? 2'd1 : 2'd0;
      tbl[r].xd = (r == 11) ? 3'b010 : 3'b000;
      tbl[r].xb = (r >= 2 && r <= 11);
    end
    tbl[0].st = 3'b010;

    #1;
    do_reset();
    chk("reset_state", {mem_trans_start, busy, grant_id, req_trans_done, req_overflow}, 10'd0);

    a1 = 32'h100; l1 = 12'd18;
    for (int r = 0; r < 13; r++) begin
      chk($sformatf("tbl%0d{start,gid,done,busy}", r),
          {mem_trans_start, grant_id, req_trans_done, busy},
          {tbl[r].xs, tbl[r].xg, tbl[r].xd, tbl[r].xb});
      if (tbl[r].xs) chk("tbl_raddr_len", {mem_raddr, mem_iolen}, {32'h100, 12'd18});
      st = tbl[r].st; dn = tbl[r].dn;
      tick();
    end

    // Three simultaneous requests after reset.
    do_reset();
    a0 = 32'h0; a1 = 32'h40; a2 = 32'h80; l0 = 12'd1; l1 = 12'd2; l2 = 12'd3;
    auto_resp = 1; resp_dly = 3;
    st = 3'b111; tick();
    repeat (30) tick();
    auto_resp = 0;
    chk("three_count", iss_q.size(), 3);
    chk("three_done_count", done_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < iss_q.size()) chk($sformatf("three_addr%0d", i), iss_q[i], 64'(i * 32'h40));
      if (i < done_q.size()) chk($sformatf("three_done%0d", i), done_q[i], 64'(1 << i));
    end

    // Fairness: requester 0 restarts in the cycle its done arrives.
    do_reset();
    a0 = 32'hA0; a2 = 32'hC0;
    st = 3'b101; tick();
    repeat (5) tick();
    a0 = 32'hA4; st = 3'b001; dn = 1'b1; tick();
    auto_resp = 1; resp_dly = 2;
    repeat (25) tick();
    auto_resp = 0;
    chk("fair_count", iss_q.size(), 3);
    if (iss_q.size() == 3) begin
      chk("fair_addrs", {iss_q[0], iss_q[1], iss_q[2]}, {32'hA0, 32'hC0, 32'hA4});
      chk("fair_grants", {gnt_q[0], gnt_q[1], gnt_q[2]}, 6'b00_10_00);
    end
    chk("fair_ovf", req_overflow, 3'b000);

    // Overflow: two extra starts from requester 2 while pending.
    do_reset();
    auto_resp = 1; resp_dly = 5;
    a2 = 32'h200; l2 = 12'd0;
    st = 3'b100; tick();
    tick();
    a2 = 32'h300; st = 3'b100; tick();
    tick();
    st = 3'b100; tick();
    repeat (20) tick();
    auto_resp = 0;
    chk("ovf_flag", req_overflow, 3'b100);
    chk("ovf_count", iss_q.size(), 1);
    if (iss_q.size() > 0) chk("ovf_addr", iss_q[0], 32'h200);
    chk("ovf_done_count", done_q.size(), 1);

    // Reset while waiting, with requester 1 still pending.
    do_reset();
    a0 = 32'h10; a1 = 32'h20;
    st = 3'b011; tick();
    tick(); tick();
    chk("rst_mid_wait", {busy, mem_trans_start, grant_id}, 4'b1000);
    st = 3'b001; tick();
    rst = 1'b1; tick();
    chk("rst_mid_state", {busy, mem_trans_start, grant_id, req_overflow}, 7'd0);
    iss_q.delete(); done_q.delete();
    tick();
    dn = 1'b1; tick();
    repeat (6) tick();
    chk("rst_mid_nodone", done_q.size(), 0);
    chk("rst_mid_noissue", iss_q.size(), 0);

    // Spurious done in IDLE and in ISSUE.
    do_reset();
    a2 = 32'h55; l2 = 12'd7;
    dn = 1'b1; st = 3'b100; tick();
    dn = 1'b1; tick();
    chk("spur_issue", {mem_trans_start, busy, grant_id}, 4'b1110);
    dn = 1'b1; tick();
    chk("spur_wait", {mem_trans_start, busy, req_trans_done}, 5'b01000);
    tick(); tick();
    dn = 1'b1; tick();
    chk("spur_done", req_trans_done, 3'b100);
    tick();
    chk("spur_idle", busy, 1'b0);

    // Random traffic against the model.
    do_reset();
    auto_resp = 1;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 3; i++) st[i] = ($urandom_range(0, 5) == 0);
      a0 = $urandom; a1 = $urandom; a2 = $urandom;
      l0 = ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom);
      l1 = AW'($urandom);
      l2 = AW'($urandom);
      resp_dly = $urandom_range(1, 6);
      if ($urandom_range(0, 24) == 0) dn = 1'b1;
      if ($urandom_range(0, 399) == 0) rst = 1'b1;
      tick();
    end
    auto_resp = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rmst_trans_arbiter.md
Name: rmst_trans_arbiter

Overview:
- Shares one external-memory read-transaction channel between three tile load controllers: input feature map (req 0), weights (req 1) and output feature map (req 2).
- Each controller issues single-burst read transactions as a one-cycle start pulse carrying a byte address and a word length.
- The arbiter queues one pending transaction per requester and grants them round-robin, one transaction at a time.
- It forwards the granted transaction to the memory read master and routes the completion pulse back to the owner.

Parameters:
AW, 12, burst length width (words)
DW, 32, address width (byte address)

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
req_trans_start  input  3  per-requester one-cycle transaction start pulse; bit i = requester i
req_raddr0  input  DW  requester 0 byte address, sampled when req_trans_start[0]=1
req_raddr1  input  DW  requester 1 byte address
req_raddr2  input  DW  requester 2 byte address
req_iolen0  input  AW  requester 0 burst length in words, sampled with start
req_iolen1  input  AW  requester 1 burst length
req_iolen2  input  AW  requester 2 burst length
req_trans_done  output  3  one-cycle completion pulse to the owning requester
mem_trans_start  output  1  one-cycle start pulse to memory read master
mem_raddr  output  DW  granted byte address, stable from the start pulse until done
mem_iolen  output  AW  granted burst length, stable from the start pulse until done
mem_trans_done  input  1  one-cycle completion pulse from memory read master
grant_id  output  2  index of current/last granted requester
busy  output  1  high while state is not ARB_IDLE
req_overflow  output  3  sticky; bit i set when requester i pulses start while already pending

Behaviour:
- Reset (rst=1 at a clk edge): state ARB_IDLE; pending=0; all outputs 0; last_grant=2, so first-round priority is 0,1,2. Reset aborts any in-flight transaction; pending requests are discarded and no done pulse is issued for them.
- Capture: when req_trans_start[i]=1 and pending[i]=0, set pending[i] and latch req_raddr{i}/req_iolen{i} into per-requester holding registers.
- Overflow: req_trans_start[i]=1 while pending[i]=1 is ignored. Holding registers are unchanged and req_overflow[i] is set. It clears only on rst.
- Exception: if the granted requester pulses start in the same cycle that mem_trans_done is sampled in ARB_WAIT, the clear and set coincide. Set wins: the new request is captured and no overflow is flagged.
- FSM states: ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_DONE.
- ARB_IDLE: if any pending bit is set, choose the first pending index searching last_grant+1, last_grant+2, last_grant+3 (mod 3). At that edge, load grant_id, mem_raddr and mem_iolen from the chosen holding register, set mem_trans_start=1, and go to ARB_ISSUE. Otherwise stay in ARB_IDLE.
- ARB_ISSUE: mem_trans_start is high for exactly this one cycle; next state ARB_WAIT.
- ARB_WAIT: hold mem_raddr and mem_iolen. On mem_trans_done=1: clear pending[grant_id], set last_grant=grant_id, register req_trans_done[grant_id]=1, go to ARB_DONE.
- ARB_DONE: req_trans_done is high for exactly this one cycle; next state ARB_IDLE.
- mem_trans_done outside ARB_WAIT is ignored and causes no state or output change.
- Latency:
  - start pulse in cycle 0 with channel idle gives pending in cycle 1 and mem_trans_start in cycle 2.
  - mem_trans_done in cycle k gives req_trans_done in cycle k+1.
  - the next mem_trans_start is no earlier than cycle k+3.
- Requests arriving while busy are queued and served in round-robin order. No requester waits more than two other transactions after it becomes pending.
- Lengths and addresses are forwarded unmodified; iolen=0 is forwarded as-is.

Test Plan:
- Single request: pulse req_trans_start=3'b010 with req_raddr1=32'h100, req_iolen1=18 at cycle 0 -> mem_trans_start in cycle 2 with mem_raddr=32'h100, mem_iolen=18, grant_id=1. Drive mem_trans_done in cycle 10 -> req_trans_done=3'b010 in cycle 11 only; busy falls in cycle 12.
- Simultaneous three requests after reset: start=3'b111 with addresses 0x0/0x40/0x80 -> memory sees 0x0, 0x40, 0x80 in that order. Each done returns to bits 0, 1, 2 respectively.
- Fairness: requester 0 re-pulses start in the cycle its done arrives, while requester 2 is pending -> grant order 0, 2, 0; requester 1 is never granted; req_overflow stays 0.
- Overflow: requester 2 pulses start twice while its first request is pending (addresses 0x200 then 0x300) -> req_overflow=3'b100. Exactly one transaction is issued, at 0x200.
- Reset mid-transaction: rst asserted in ARB_WAIT with requester 1 pending -> next cycle busy=0, mem_trans_start=0, grant_id=0, req_overflow=0. A later mem_trans_done produces no req_trans_done pulse.
- Spurious done: mem_trans_done pulsed in ARB_IDLE and in ARB_ISSUE -> no req_trans_done, state sequence unchanged.
